// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle instruction sequencer with an 8-bit ALU, driving an 8x8 register file.
// Sequence per instruction: FETCH -> DECODE -> EXECUTE -> WRITEBACK (NOP/illegal skip to FETCH).
module cpu_ctrl_seq #(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                Start,
   output logic                InstrReq,
   output logic [PC_WIDTH-1:0] InstrAdrs,
   input  logic [15:0]         InstrData,
   input  logic                InstrValid,
   output logic [2:0]          RdAdrsA,
   output logic [2:0]          RdAdrsB,
   input  logic [7:0]          RdDataA,
   input  logic [7:0]          RdDataB,
   output logic                LdReg,
   output logic [2:0]          WtAdrs,
   output logic [7:0]          WtData,
   output logic                Zero,
   output logic                Carry,
   output logic                Busy,
   output logic                Halted,
   output logic [2:0]          stateDbg
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      WRITEBACK = 3'd4,
      HALTED    = 3'd5
   } state_t;

   state_t              state;
   logic [PC_WIDTH-1:0] pc;
   logic [15:0]         ir;
   logic [7:0]          result;
   logic                zeroFlag;
   logic                carryFlag;

   logic [3:0] op;
   logic [8:0] aluRes;
   logic       setFlags;
   logic       isSkip;

   assign op = ir[15:12];
   // Opcodes 0 and B..E fall straight back to FETCH without touching registers or flags.
   assign isSkip = (op == 4'h0) || ((op > 4'hA) && (op != 4'hF));

   // aluRes[8] carries the carry, borrow or shifted-out bit.
   always_comb begin
      aluRes   = 9'd0;
      setFlags = 1'b0;
      case (op)
         4'h1: begin aluRes = {1'b0, RdDataA} + {1'b0, RdDataB}; setFlags = 1'b1; end
         4'h2: begin aluRes = {1'b0, RdDataA} - {1'b0, RdDataB}; setFlags = 1'b1; end
         4'h3: begin aluRes = {1'b0, RdDataA & RdDataB};         setFlags = 1'b1; end
         4'h4: begin aluRes = {1'b0, RdDataA | RdDataB};         setFlags = 1'b1; end
         4'h5: begin aluRes = {1'b0, RdDataA ^ RdDataB};         setFlags = 1'b1; end
         4'h6: begin aluRes = {1'b0, ~RdDataA};                  setFlags = 1'b1; end
         4'h7: aluRes = {1'b0, RdDataA};
         4'h8: aluRes = {1'b0, ir[7:0]};
         4'h9: begin aluRes = {RdDataA, 1'b0};                   setFlags = 1'b1; end
         4'hA: begin aluRes = {RdDataA[0], 1'b0, RdDataA[7:1]};  setFlags = 1'b1; end
         default: aluRes = 9'd0;
      endcase
   end

   // Fetch handshake: InstrReq is held while in FETCH; the word is taken on the first
   // rising edge where InstrValid=1, and InstrValid is ignored in every other state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         ir        <= 16'd0;
         result    <= 8'd0;
         zeroFlag  <= 1'b0;
         carryFlag <= 1'b0;
      end else begin
         case (state)
            IDLE: if (Start) state <= FETCH;
            FETCH: begin
               if (InstrValid) begin
                  ir    <= InstrData;
                  state <= DECODE;
               end
            end
            DECODE: begin
               if (op == 4'hF) begin
                  state <= HALTED;
               end else if (isSkip) begin
                  pc    <= pc + PC_WIDTH'(1);
                  state <= FETCH;
               end else begin
                  state <= EXECUTE;
               end
            end
            EXECUTE: begin
               result <= aluRes[7:0];
               if (setFlags) begin
                  zeroFlag  <= (aluRes[7:0] == 8'd0);
                  carryFlag <= aluRes[8];
               end
               state <= WRITEBACK;
            end
            WRITEBACK: begin
               pc    <= pc + PC_WIDTH'(1);
               state <= FETCH;
            end
            HALTED: state <= HALTED;
            default: state <= IDLE;
         endcase
      end
   end

   assign InstrReq  = (state == FETCH);
   assign InstrAdrs = pc;
   assign RdAdrsA   = ir[8:6];
   assign RdAdrsB   = ir[5:3];
   assign WtAdrs    = ir[11:9];
   assign LdReg     = (state == WRITEBACK);
   assign WtData    = result;
   assign Zero      = zeroFlag;
   assign Carry     = carryFlag;
   assign Busy      = (state == FETCH) || (state == DECODE) || (state == EXECUTE) || (state == WRITEBACK);
   assign Halted    = (state == HALTED);
   assign stateDbg  = state;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: register file and instruction memory models around the DUT,
// plus a second instance with RESET_PC=0xFE for PC wrap.
module tb_cpu_ctrl_seq;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int testsRun = 0;
   int testsFailed = 0;

   // ---------------- DUT 1 (RESET_PC = 0) ----------------
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic        InstrReq;
   logic [7:0]  InstrAdrs;
   logic [15:0] InstrData = 16'd0;
   logic        InstrValid = 1'b0;
   logic [2:0]  RdAdrsA, RdAdrsB, WtAdrs;
   logic [7:0]  RdDataA, RdDataB, WtData;
   logic        LdReg, Zero, Carry, Busy, Halted;
   logic [2:0]  stateDbg;

   cpu_ctrl_seq #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .reset(reset), .Start(Start),
      .InstrReq(InstrReq), .InstrAdrs(InstrAdrs), .InstrData(InstrData), .InstrValid(InstrValid),
      .RdAdrsA(RdAdrsA), .RdAdrsB(RdAdrsB), .RdDataA(RdDataA), .RdDataB(RdDataB),
      .LdReg(LdReg), .WtAdrs(WtAdrs), .WtData(WtData),
      .Zero(Zero), .Carry(Carry), .Busy(Busy), .Halted(Halted), .stateDbg(stateDbg)
   );

   // ---------------- DUT 2 (RESET_PC = 0xFE) ----------------
   logic        reset2 = 1'b1;
   logic        Start2 = 1'b0;
   logic        InstrReq2;
   logic [7:0]  InstrAdrs2;
   logic [15:0] InstrData2;
   logic        InstrValid2 = 1'b1;
   logic [2:0]  RdAdrsA2, RdAdrsB2, WtAdrs2;
   logic [7:0]  RdDataA2 = 8'h00;
   logic [7:0]  RdDataB2 = 8'h00;
   logic [7:0]  WtData2;
   logic        LdReg2, Zero2, Carry2, Busy2, Halted2;
   logic [2:0]  stateDbg2;

   cpu_ctrl_seq #(.PC_WIDTH(8), .RESET_PC(8'hFE)) dut2 (
      .clk(clk), .reset(reset2), .Start(Start2),
      .InstrReq(InstrReq2), .InstrAdrs(InstrAdrs2), .InstrData(InstrData2), .InstrValid(InstrValid2),
      .RdAdrsA(RdAdrsA2), .RdAdrsB(RdAdrsB2), .RdDataA(RdDataA2), .RdDataB(RdDataB2),
      .LdReg(LdReg2), .WtAdrs(WtAdrs2), .WtData(WtData2),
      .Zero(Zero2), .Carry(Carry2), .Busy(Busy2), .Halted(Halted2), .stateDbg(stateDbg2)
   );

   // ---------------- models ----------------
   logic [15:0] imem  [256];
   logic [15:0] imem2 [256];
   logic [7:0]  rf    [8];
   int          wrCount = 0;
   int          widthErr = 0;
   logic        ldPrev = 1'b0;
   int          stallLen = 0;
   int          reqCycles = 0;
   logic [7:0]  fetchLog [$];

   assign RdDataA    = rf[RdAdrsA];
   assign RdDataB    = rf[RdAdrsB];
   assign InstrData2 = imem2[InstrAdrs2];

   // Register file write port plus pulse-width watch.
   always @(posedge clk) begin
      if (LdReg) begin
         rf[WtAdrs] <= WtData;
         wrCount++;
         if (ldPrev) widthErr++;
      end
      ldPrev = LdReg;
   end

   // Instruction memory responder, optionally stalling each fetch by stallLen cycles.
   always @(negedge clk) begin
      if (InstrReq) begin
         if (reqCycles < stallLen) begin
            InstrValid = 1'b0;
            reqCycles++;
         end else begin
            InstrValid = 1'b1;
            InstrData  = imem[InstrAdrs];
            reqCycles  = 0;
         end
      end else begin
         InstrValid = 1'b0;
         reqCycles  = 0;
      end
   end

   always @(posedge clk) begin
      if (InstrReq2 && InstrValid2) fetchLog.push_back(InstrAdrs2);
   end

   // ---------------- driver tasks ----------------
   task automatic clear_prog();
      for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      Start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Pulses Start, then counts rising edges until Halted (bounded).
   task automatic run_program(output int cycles);
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      cycles = 0;
      while (!Halted && cycles < 300) begin
         @(posedge clk);
         #1 cycles++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      testsRun++; if (InstrReq !== 1'b0) begin testsFailed++; $display("FAIL reset_instrreq got=%b exp=0", InstrReq); end
      testsRun++; if (InstrAdrs !== 8'h00) begin testsFailed++; $display("FAIL reset_instradrs got=%h exp=00", InstrAdrs); end
      testsRun++; if (LdReg !== 1'b0) begin testsFailed++; $display("FAIL reset_ldreg got=%b exp=0", LdReg); end
      testsRun++; if ({Busy, Halted, Zero, Carry} !== 4'b0000) begin testsFailed++; $display("FAIL reset_flags got=%b exp=0000", {Busy, Halted, Zero, Carry}); end
      testsRun++; if (WtData !== 8'h00) begin testsFailed++; $display("FAIL reset_wtdata got=%h exp=00", WtData); end
      testsRun++; if ({WtAdrs, RdAdrsA, RdAdrsB} !== 9'd0) begin testsFailed++; $display("FAIL reset_adrs got=%h exp=0", {WtAdrs, RdAdrsA, RdAdrsB}); end
      testsRun++; if (stateDbg !== 3'd0) begin testsFailed++; $display("FAIL reset_state got=%0d exp=0", stateDbg); end
      testsRun++; if (InstrAdrs2 !== 8'hFE) begin testsFailed++; $display("FAIL reset_pc2 got=%h exp=fe", InstrAdrs2); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add();
      int cyc, w0, e0;
      clear_prog();
      imem[0] = 16'h823C; imem[1] = 16'h84C4; imem[2] = 16'h1650;
      do_reset();
      w0 = wrCount; e0 = widthErr;
      run_program(cyc);
      testsRun++; if (cyc !== 14) begin testsFailed++; $display("FAIL add_cycles got=%0d exp=14", cyc); end
      testsRun++; if ({rf[1], rf[2], rf[3]} !== 24'h3CC400) begin testsFailed++; $display("FAIL add_regs got=%h exp=3cc400", {rf[1], rf[2], rf[3]}); end
      testsRun++; if ({Zero, Carry} !== 2'b11) begin testsFailed++; $display("FAIL add_flags got=%b exp=11", {Zero, Carry}); end
      testsRun++; if (wrCount - w0 !== 3) begin testsFailed++; $display("FAIL add_ldreg_count got=%0d exp=3", wrCount - w0); end
      testsRun++; if (widthErr - e0 !== 0) begin testsFailed++; $display("FAIL add_ldreg_width got=%0d exp=0", widthErr - e0); end
      testsRun++; if ({Halted, Busy, InstrAdrs} !== {2'b10, 8'h03}) begin testsFailed++; $display("FAIL add_halt got=%h exp=203", {Halted, Busy, InstrAdrs}); end
   endtask

   task automatic test_sub();
      logic [7:0] aVal [2] = '{8'h05, 8'h07};
      logic [7:0] bVal [2] = '{8'h07, 8'h05};
      logic [7:0] expR [2] = '{8'hFE, 8'h02};
      logic       expC [2] = '{1'b1, 1'b0};
      int cyc;
      for (int k = 0; k < 2; k++) begin
         clear_prog();
         imem[0] = {8'h82, aVal[k]}; imem[1] = {8'h84, bVal[k]}; imem[2] = 16'h2850;
         do_reset();
         run_program(cyc);
         testsRun++; if (rf[4] !== expR[k]) begin testsFailed++; $display("FAIL sub_result[%0d] got=%h exp=%h", k, rf[4], expR[k]); end
         testsRun++; if ({Zero, Carry} !== {1'b0, expC[k]}) begin testsFailed++; $display("FAIL sub_flags[%0d] got=%b exp=%b", k, {Zero, Carry}, {1'b0, expC[k]}); end
      end
   endtask

   task automatic test_alu_ops();
      logic [15:0] prog [12] = '{16'h8281, 16'h840F, 16'h3650, 16'h4850, 16'h5A50, 16'h6C40,
                                 16'h9E40, 16'hA040, 16'h1248, 16'h5648, 16'h7440, 16'hF000};
      logic [7:0] expRf [8] = '{8'h40, 8'h02, 8'h02, 8'h00, 8'h8F, 8'h8E, 8'h7E, 8'h02};
      int cyc, w0;
      clear_prog();
      for (int i = 0; i < 12; i++) imem[i] = prog[i];
      do_reset();
      w0 = wrCount;
      run_program(cyc);
      for (int r = 0; r < 8; r++) begin
         testsRun++; if (rf[r] !== expRf[r]) begin testsFailed++; $display("FAIL ops_r%0d got=%h exp=%h", r, rf[r], expRf[r]); end
      end
      testsRun++; if ({Zero, Carry} !== 2'b10) begin testsFailed++; $display("FAIL ops_mov_keeps_flags got=%b exp=10", {Zero, Carry}); end
      testsRun++; if (wrCount - w0 !== 11) begin testsFailed++; $display("FAIL ops_ldreg_count got=%0d exp=11", wrCount - w0); end
   endtask

   task automatic test_stall();
      int n, w0;
      clear_prog();
      imem[0] = 16'h8AA5;
      stallLen = 5;
      do_reset();
      w0 = wrCount;
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         testsRun++; if ({InstrReq, InstrAdrs, LdReg} !== {1'b1, 8'h00, 1'b0}) begin testsFailed++; $display("FAIL stall_cycle%0d got=%h exp=200", c, {InstrReq, InstrAdrs, LdReg}); end
      end
      n = 0;
      while (!Halted && n < 100) begin
         @(posedge clk);
         #1 n++;
      end
      testsRun++; if (Halted !== 1'b1) begin testsFailed++; $display("FAIL stall_timeout got=%b exp=1", Halted); end
      testsRun++; if (rf[5] !== 8'hA5) begin testsFailed++; $display("FAIL stall_result got=%h exp=a5", rf[5]); end
      testsRun++; if (wrCount - w0 !== 1) begin testsFailed++; $display("FAIL stall_ldreg_count got=%0d exp=1", wrCount - w0); end
      stallLen = 0;
   endtask

   task automatic test_nop_halt();
      int cyc, w0;
      clear_prog();
      imem[0] = 16'h0000; imem[1] = 16'hB123; imem[2] = 16'h0000; imem[3] = 16'hC000; imem[4] = 16'hE000;
      do_reset();
      w0 = wrCount;
      run_program(cyc);
      testsRun++; if (cyc !== 12) begin testsFailed++; $display("FAIL nop_cycles got=%0d exp=12", cyc); end
      testsRun++; if (wrCount - w0 !== 0) begin testsFailed++; $display("FAIL nop_ldreg_count got=%0d exp=0", wrCount - w0); end
      testsRun++; if ({Halted, Busy, InstrAdrs} !== {2'b10, 8'h05}) begin testsFailed++; $display("FAIL halt_state got=%h exp=205", {Halted, Busy, InstrAdrs}); end
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      testsRun++; if ({Halted, Busy, InstrReq, InstrAdrs} !== {3'b100, 8'h05}) begin testsFailed++; $display("FAIL halt_ignores_start got=%h exp=405", {Halted, Busy, InstrReq, InstrAdrs}); end
   endtask

   task automatic test_reset_writeback();
      int cyc, n, w0;
      clear_prog();
      imem[0] = 16'h8C11;
      do_reset();
      run_program(cyc);
      testsRun++; if (rf[6] !== 8'h11) begin testsFailed++; $display("FAIL rstwb_setup got=%h exp=11", rf[6]); end
      imem[0] = 16'h8C5A;
      do_reset();
      w0 = wrCount;
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      n = 0;
      while (!LdReg && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      testsRun++; if (LdReg !== 1'b1) begin testsFailed++; $display("FAIL rstwb_reach_wb got=%b exp=1", LdReg); end
      reset = 1'b1;
      #1;
      testsRun++; if ({LdReg, Busy, InstrReq, stateDbg} !== 6'd0) begin testsFailed++; $display("FAIL rstwb_async got=%b exp=000000", {LdReg, Busy, InstrReq, stateDbg}); end
      @(posedge clk);
      #1;
      testsRun++; if (rf[6] !== 8'h11) begin testsFailed++; $display("FAIL rstwb_no_write got=%h exp=11", rf[6]); end
      testsRun++; if (wrCount - w0 !== 0) begin testsFailed++; $display("FAIL rstwb_ldreg_count got=%0d exp=0", wrCount - w0); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_wrap();
      logic [7:0] expAdr [3] = '{8'hFE, 8'hFF, 8'h00};
      logic [7:0] got;
      int n;
      @(negedge clk);
      reset2 = 1'b0;
      @(negedge clk);
      Start2 = 1'b1;
      @(posedge clk);
      #1 Start2 = 1'b0;
      n = 0;
      while (!Halted2 && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      testsRun++; if (Halted2 !== 1'b1) begin testsFailed++; $display("FAIL wrap_timeout got=%b exp=1", Halted2); end
      testsRun++; if (fetchLog.size() !== 3) begin testsFailed++; $display("FAIL wrap_fetch_count got=%0d exp=3", fetchLog.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < fetchLog.size()) ? fetchLog[i] : 8'hxx;
         testsRun++; if (got !== expAdr[i]) begin testsFailed++; $display("FAIL wrap_fetch%0d got=%h exp=%h", i, got, expAdr[i]); end
      end
      testsRun++; if (InstrAdrs2 !== 8'h00) begin testsFailed++; $display("FAIL wrap_final_pc got=%h exp=00", InstrAdrs2); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      for (int i = 0; i < 256; i++) imem2[i] = 16'hF000;
      imem2[8'hFE] = 16'h8201;
      imem2[8'hFF] = 16'h8402;
      clear_prog();
      repeat (2) @(posedge clk);
      test_reset();
      test_add();
      test_sub();
      test_alu_ops();
      test_stall();
      test_nop_halt();
      test_reset_writeback();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Multi-cycle instruction sequencer with integrated 8-bit ALU, sitting directly upstream of the 8x8 register file.
- Fetches 16-bit instructions over a request/valid handshake and decodes them.
- Drives the register file read addresses, consumes RdDataA/RdDataB, and computes the result.
- Writes the result back through LdReg/WtAdrs/WtData.

Parameters:
- PC_WIDTH, 8, width of program counter and instruction address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Start  in  1  begin execution from PC when in IDLE.
- InstrReq  out  1  instruction fetch request.
- InstrAdrs  out  PC_WIDTH  fetch address (current PC).
- InstrData  in  16  instruction word, sampled when InstrValid=1 during FETCH.
- InstrValid  in  1  InstrData valid this cycle.
- RdAdrsA  out  3  register file read address A (IR[8:6]).
- RdAdrsB  out  3  register file read address B (IR[5:3]).
- RdDataA  in  8  register file read data A (combinational from RdAdrsA).
- RdDataB  in  8  register file read data B.
- LdReg  out  1  register file write enable.
- WtAdrs  out  3  register file write address (IR[11:9]).
- WtData  out  8  register file write data (result register).
- Zero  out  1  zero flag.
- Carry  out  1  carry/borrow/shift-out flag.
- Busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK.
- Halted  out  1  high in HALTED.

Behaviour:
- Reset (async): state=IDLE, PC=RESET_PC, IR=0, result=0, Zero=0, Carry=0. All outputs 0 except InstrAdrs=RESET_PC. Takes effect mid-instruction; any pending write is abandoned and LdReg drops immediately.
- Instruction format: op=IR[15:12], Rd=IR[11:9], Ra=IR[8:6], Rb=IR[5:3], imm8=IR[7:0]. RdAdrsA, RdAdrsB, and WtAdrs are driven from IR fields at all times.
- Opcodes: 0 NOP; 1 ADD; 2 SUB (Ra-Rb); 3 AND; 4 OR; 5 XOR; 6 NOT Ra; 7 MOV Ra; 8 LDI imm8; 9 SHL Ra by 1; A SHR Ra by 1 (logical); F HALT. Opcodes B-E are treated as NOP.
- IDLE: InstrReq=0. Start=1 moves to FETCH.
- FETCH: InstrReq=1, InstrAdrs=PC. Stays in FETCH while InstrValid=0 (no timeout). On InstrValid=1, IR<=InstrData and go to DECODE. InstrValid outside FETCH is ignored.
- DECODE: read addresses settle.
  - NOP/illegal: PC<=PC+1, go to FETCH.
  - HALT: go to HALTED, PC unchanged.
  - Otherwise: go to EXECUTE.
- EXECUTE: result<=ALU(RdDataA,RdDataB,imm8). 8-bit result, carry is a 9th bit. Flag updates:
  - ADD: Carry=bit8 of sum.
  - SUB: Carry=1 iff Ra<Rb unsigned (borrow).
  - SHL: Carry=Ra[7].
  - SHR: Carry=Ra[0].
  - AND/OR/XOR/NOT: Carry=0.
  - Zero=(result==0) for ops 1-6, 9, A.
  - MOV and LDI leave both flags unchanged.
  - Next state: WRITEBACK.
- WRITEBACK: LdReg=1 for exactly this one cycle; WtData=result, WtAdrs=Rd. PC<=PC+1, go to FETCH.
- Latency: 4 cycles per ALU/MOV/LDI instruction with zero-wait fetch; 2 cycles for NOP.
- PC increments modulo 2^PC_WIDTH (0xFF -> 0x00 at default).
- Start is ignored outside IDLE. HALTED is left only by reset.
- Rd may equal Ra/Rb. Operands are read in EXECUTE, before the write in WRITEBACK, so old values are used.
- LdReg is never high outside WRITEBACK.

Test Plan:
- Reset then Start; program LDI R1,0x3C; LDI R2,0xC4; ADD R3,R1,R2 -> R3=0x00, Zero=1, Carry=1; LdReg pulses exactly 3 times, each 1 cycle wide.
- SUB R4,R1,R2 with R1=0x05, R2=0x07 -> R4=0xFE, Carry=1, Zero=0. SUB with R1=0x07, R2=0x05 -> 0x02, Carry=0.
- Hold InstrValid low 5 cycles in FETCH -> InstrReq stays 1, InstrAdrs stable, no LdReg. Then assert InstrValid -> normal completion.
- Opcode 0xB and NOP -> no LdReg pulse, PC+1, 2 cycles each. HALT at PC=0x05 -> Halted=1, Busy=0, InstrAdrs stays 0x05, Start ignored.
- Assert reset during WRITEBACK (LdReg=1) -> LdReg=0 and state IDLE before next clk edge; the register is not written.
- Start with RESET_PC=0xFE, two LDI instructions -> fetch addresses 0xFE, 0xFF, 0x00 (wrap).
